// File: rtl/lsu_warp.sv
// rtl/lsu_warp.sv - warp-wide load/store unit serialising active lanes onto one data-memory port
module lsu_warp #(
   parameter int NUM_LANES  = 8,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic                            ack,
   input  logic [NUM_LANES-1:0]            lane_mask,
   input  logic                            op_read,
   input  logic                            op_write,
   input  logic [1:0]                      size,
   input  logic                            sign_ext,
   input  logic [NUM_LANES*DATA_WIDTH-1:0] rs1,
   input  logic [NUM_LANES*DATA_WIDTH-1:0] rs2,
   input  logic [DATA_WIDTH-1:0]           imm,
   output logic                            mem_read_valid,
   output logic [ADDR_WIDTH-1:0]           mem_read_address,
   input  logic                            mem_read_ready,
   input  logic [DATA_WIDTH-1:0]           mem_read_data,
   output logic                            mem_write_valid,
   output logic [ADDR_WIDTH-1:0]           mem_write_address,
   output logic [DATA_WIDTH-1:0]           mem_write_data,
   output logic [DATA_WIDTH/8-1:0]         mem_write_strb,
   input  logic                            mem_write_ready,
   output logic [1:0]                      lsu_state,
   output logic [NUM_LANES*DATA_WIDTH-1:0] lsu_out,
   output logic [NUM_LANES-1:0]            lsu_out_valid,
   output logic [NUM_LANES-1:0]            fault
);

   localparam int BYTES  = DATA_WIDTH / 8;
   localparam int OFF_W  = $clog2(BYTES);
   localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t state, state_next;

   logic [NUM_LANES-1:0]            pending;
   logic                            op_read_q;
   logic [1:0]                      size_q;
   logic                            sign_ext_q;
   logic [NUM_LANES*DATA_WIDTH-1:0] rs1_q;
   logic [NUM_LANES*DATA_WIDTH-1:0] rs2_q;
   logic [DATA_WIDTH-1:0]           imm_q;

   logic                  accept;
   logic [NUM_LANES-1:0]  remaining;
   logic [LANE_W-1:0]     sel;
   int                    sel_base;
   logic [DATA_WIDTH-1:0] rs1_lane, rs2_lane;
   logic [DATA_WIDTH-1:0] lane_ea, ea_word;
   logic [OFF_W-1:0]      lane_off;
   logic [ADDR_WIDTH-1:0] lane_addr;
   logic                  lane_fault;
   logic [DATA_WIDTH-1:0] st_data;
   logic [BYTES-1:0]      strb_base, st_strb;
   logic [DATA_WIDTH-1:0] rd_shift, ld_mask, ld_val;
   logic                  ld_sign;
   logic                  port_ready;

   assign accept     = start && (op_read ^ op_write);
   // Pending with its lowest set bit cleared: the lanes left after the current one.
   assign remaining  = pending & (pending - NUM_LANES'(1));
   assign port_ready = op_read_q ? mem_read_ready : mem_write_ready;
   assign lsu_state  = state;

   always_comb begin
      sel = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (pending[i]) sel = LANE_W'(i);
      end
   end

   assign sel_base  = int'(sel) * DATA_WIDTH;
   assign rs1_lane  = rs1_q[sel_base +: DATA_WIDTH];
   assign rs2_lane  = rs2_q[sel_base +: DATA_WIDTH];
   assign lane_ea   = rs1_lane + imm_q;
   assign lane_off  = lane_ea[OFF_W-1:0];
   assign ea_word   = lane_ea >> OFF_W;
   assign lane_addr = ADDR_WIDTH'(ea_word);

   always_comb begin
      lane_fault = 1'b0;
      case (size_q)
         2'd0:    lane_fault = 1'b0;
         2'd1:    lane_fault = lane_off[0];
         2'd2:    lane_fault = (lane_off != '0);
         default: lane_fault = 1'b1;
      endcase
   end

   // Sub-word stores replicate the datum so the strobe alone picks the byte lanes.
   always_comb begin
      st_data   = rs2_lane;
      strb_base = '1;
      ld_mask   = '1;
      ld_sign   = 1'b0;
      rd_shift  = mem_read_data >> {lane_off, 3'b000};
      case (size_q)
         2'd0: begin
            st_data   = {BYTES{rs2_lane[7:0]}};
            strb_base = BYTES'(1);
            ld_mask   = DATA_WIDTH'(8'hFF);
            ld_sign   = rd_shift[7];
         end
         2'd1: begin
            st_data   = {(BYTES/2){rs2_lane[15:0]}};
            strb_base = BYTES'(3);
            ld_mask   = DATA_WIDTH'(16'hFFFF);
            ld_sign   = rd_shift[15];
         end
         default: begin
            st_data   = rs2_lane;
            strb_base = '1;
         end
      endcase
      st_strb = strb_base << lane_off;
      ld_val  = rd_shift & ld_mask;
      if (sign_ext_q && ld_sign) ld_val = ld_val | ~ld_mask;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (accept) state_next = (lane_mask == '0) ? S_DONE : S_REQ;
         end
         S_REQ: begin
            if (pending == '0)   state_next = S_DONE;
            else if (lane_fault) state_next = (remaining == '0) ? S_DONE : S_REQ;
            else                 state_next = S_WAIT;
         end
         S_WAIT: begin
            if (port_ready) state_next = (remaining == '0) ? S_DONE : S_REQ;
         end
         S_DONE: begin
            if (ack) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending           <= '0;
         op_read_q         <= 1'b0;
         size_q            <= '0;
         sign_ext_q        <= 1'b0;
         rs1_q             <= '0;
         rs2_q             <= '0;
         imm_q             <= '0;
         mem_read_valid    <= 1'b0;
         mem_read_address  <= '0;
         mem_write_valid   <= 1'b0;
         mem_write_address <= '0;
         mem_write_data    <= '0;
         mem_write_strb    <= '0;
         lsu_out           <= '0;
         lsu_out_valid     <= '0;
         fault             <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  pending       <= lane_mask;
                  op_read_q     <= op_read;
                  size_q        <= size;
                  sign_ext_q    <= sign_ext;
                  rs1_q         <= rs1;
                  rs2_q         <= rs2;
                  imm_q         <= imm;
                  lsu_out       <= '0;
                  lsu_out_valid <= '0;
                  fault         <= '0;
               end
            end
            S_REQ: begin
               if (pending != '0) begin
                  if (lane_fault) begin
                     fault[sel]   <= 1'b1;
                     pending[sel] <= 1'b0;
                  end else if (op_read_q) begin
                     mem_read_valid   <= 1'b1;
                     mem_read_address <= lane_addr;
                  end else begin
                     mem_write_valid   <= 1'b1;
                     mem_write_address <= lane_addr;
                     mem_write_data    <= st_data;
                     mem_write_strb    <= st_strb;
                  end
               end
            end
            S_WAIT: begin
               if (port_ready) begin
                  mem_read_valid  <= 1'b0;
                  mem_write_valid <= 1'b0;
                  pending[sel]    <= 1'b0;
                  if (op_read_q) begin
                     lsu_out[sel_base +: DATA_WIDTH] <= ld_val;
                     lsu_out_valid[sel]              <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/lsu_warp.md
# lsu_warp

Warp-wide load-store unit that serves every thread lane of a warp through a single shared data-memory port, one lane at a time in ascending lane order. It adds byte/halfword/word access sizes with sign or zero extension, byte write strobes and per-lane misalignment faults. It sits between the warp scheduler, which issues `start` and `ack`, and the data-memory arbiter, using the same valid/ready request style as the per-thread LSU.

## Interface
- `NUM_LANES`, 8: thread lanes per warp (≥1).
- `DATA_WIDTH`, 32: register and memory word width; power of two, ≥16.
- `ADDR_WIDTH`, 32: width of the memory word address.
- `clk` input 1: clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all state and outputs immediately while low.
- `start` input 1: scheduler request; sampled only in IDLE.
- `ack` input 1: scheduler retire; sampled only in DONE.
- `lane_mask` input NUM_LANES: active lanes; latched at `start`.
- `op_read`, `op_write` input 1 each: load or store; latched at `start`.
- `size` input 2: 0 = byte, 1 = half, 2 = word, 3 = reserved; latched at `start`.
- `sign_ext` input 1: sign-extend loads when 1; latched at `start`.
- `rs1` input NUM_LANES*DATA_WIDTH: per-lane byte base address; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]; latched at `start`.
- `rs2` input NUM_LANES*DATA_WIDTH: per-lane store data; latched at `start`.
- `imm` input DATA_WIDTH: offset shared by all lanes; latched at `start`.
- `mem_read_valid` output 1, `mem_read_address` output ADDR_WIDTH, `mem_read_ready` input 1, `mem_read_data` input DATA_WIDTH.
- `mem_write_valid` output 1, `mem_write_address` output ADDR_WIDTH, `mem_write_data` output DATA_WIDTH, `mem_write_strb` output DATA_WIDTH/8, `mem_write_ready` input 1.
- `lsu_state` output 2: IDLE = 0, REQUESTING = 1, WAITING = 2, DONE = 3.
- `lsu_out` output NUM_LANES*DATA_WIDTH: per-lane load result.
- `lsu_out_valid` output NUM_LANES: lane completed a load.
- `fault` output NUM_LANES: lane was skipped as misaligned.

## Operation
- **Byte address.** Lane byte address is `ea = rs1[i] + imm`, modulo 2^DATA_WIDTH.
  - Word address is `ea >> log2(DATA_WIDTH/8)`, truncated to ADDR_WIDTH.
  - Offset is `off = ea[log2(DATA_WIDTH/8)-1:0]`.
- **Misalignment.** A lane faults when any of the following holds:
  - `size` = 1 and `off[0]` = 1;
  - `size` = 2 and `off` ≠ 0;
  - `size` = 3 (any address).
- **Store data and strobe.**
  - `mem_write_data` is the low 8 or 16 bits of `rs2` replicated across the word, or all of `rs2` for word size.
  - `mem_write_strb` is 1, 3 or all-ones, shifted left by `off`.
- **Load result.**
  - Take `mem_read_data >> (8*off)` and keep the low 8, 16 or DATA_WIDTH bits.
  - Extend to DATA_WIDTH: sign extension if `sign_ext` = 1, zero extension otherwise.
- **IDLE.**
  - On `start` with exactly one of `op_read`/`op_write` high: latch all operands, set `pending = lane_mask`, clear `lsu_out`, `lsu_out_valid` and `fault`.
  - Then go to DONE if `lane_mask` = 0, else to REQUESTING.
  - `start` with both or neither op high is ignored (stay IDLE, no output change).
- **REQUESTING.** Select the lowest set bit of `pending`.
  - If the lane faults: set `fault[i]` and clear `pending[i]`. Go to DONE if no lanes remain, else stay in REQUESTING.
  - Otherwise: register `valid=1`, address, and for stores data and strobe on the op's port. Go to WAITING.
- **WAITING.**
  - Hold valid, address, data and strobe stable.
  - When the op's ready is sampled high: drop valid, clear `pending[i]`. For loads, also write `lsu_out[i]` and set `lsu_out_valid[i]`.
  - Then go to REQUESTING if lanes remain, else to DONE.
  - Ready seen while in REQUESTING is ignored.
- **DONE.**
  - Results stay stable.
  - On `ack`, go to IDLE. Results persist until the next accepted `start`.
- `start` outside IDLE and `ack` outside DONE are ignored.
- The read port is never active during a store, and the write port never during a load.

## Timing
- **Reset values.** All outputs are 0. `lsu_state` is IDLE. Internal `pending` is 0.
- **Reset mid-operation.** Valid drops asynchronously; the in-flight access is abandoned with no retry.
- **Lane cost.**
  - Non-faulting lane: 1 REQUESTING cycle plus ≥1 WAITING cycles (exactly 2 with ready tied high).
  - Faulting lane: 1 REQUESTING cycle.
- **Latency.** With ready tied high, N good lanes and F faulting lanes: DONE is reached 1 + 2N + F cycles after the `start` edge.
  - An empty mask reaches DONE 1 cycle after `start`.
- **Handshake.** Valid rises at the edge leaving REQUESTING. It falls at the edge on which ready is sampled high, so at most one request is outstanding.
- **Back-to-back.** The minimum gap between consecutive memory requests is one cycle with valid low.

## Test plan
- **Load, word, full warp.** `NUM_LANES`=8, mask 0xFF, `rs1[i]`=4i, `imm`=16, memory word k = 100+k, ready tied high.
  - Read addresses 4..11 in lane order.
  - `lsu_out[i]` = 104+i; `lsu_out_valid` = 0xFF.
  - DONE after 17 cycles.
- **Sparse mask with ready delay.** Mask 0x05, `mem_write_ready` delayed 3 cycles.
  - Exactly two writes (lanes 0 then 2); valid and data held stable across the wait.
  - Lanes 1 and 3–7 untouched.
- **Sub-word access.**
  - Byte store of `rs2` = 0x1234_56AB to `ea` = 0x13: `mem_write_data` = 0xABABABAB, `strb` = 0b1000, address 4.
  - Byte load of 0x80 at `off` 3: 0xFFFF_FF80 with `sign_ext`=1, 0x0000_0080 with `sign_ext`=0.
- **Misalignment.** Word load with mask 0x03, lane 1 `ea` = 0x6.
  - `fault` = 0x02, `lsu_out_valid` = 0x01, only one read issued.
  - DONE after 4 cycles.
- **Control corner cases.**
  - `start` with `op_read`=`op_write`=1: no state change.
  - Mask 0: IDLE→DONE in 1 cycle, no memory traffic.
  - `start` pulsed during WAITING: ignored.
  - DONE holds until `ack`.
- **Async reset.** Drop `reset` mid-WAITING: valid and all outputs are 0 immediately, state is IDLE. The next `start` runs normally.
